// File: rtl/cp0.sv
// cp0: system coprocessor 0 (SR, Cause, EPC, PRId) for the multi-cycle MIPS core.
// Ports: clk/rst; A1 read sel, A2/DIn/We MTC0 write; PC/EPCWr EPC capture;
//   EXLSet/EXLClr exception entry/ERET; HWInt[7:2] lines; IntReq, EPC, DOut out.
module cp0 #(
  parameter logic [31:0] PRID_VAL = 32'h0000_4D50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic [29:0] PC,
  input  logic [5:0]  HWInt,
  input  logic        We,
  input  logic        EXLSet,
  input  logic        EXLClr,
  input  logic        EPCWr,
  output logic        IntReq,
  output logic [29:0] EPC,
  output logic [31:0] DOut
);

  localparam logic [4:0] R_SR    = 5'd12;
  localparam logic [4:0] R_CAUSE = 5'd13;
  localparam logic [4:0] R_EPC   = 5'd14;
  localparam logic [4:0] R_PRID  = 5'd15;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [5:0]  ip;
  logic [29:0] epc_q;

  // FSM strobes take the cycle; only a bare We is a software write.
  logic sw_wr;
  logic wr_sr;
  logic wr_epc;

  assign sw_wr  = We & ~EXLSet & ~EXLClr;
  assign wr_sr  = sw_wr & (A2 == R_SR);
  assign wr_epc = sw_wr & (A2 == R_EPC);

  // SR
  always_ff @(posedge clk) begin
    if (rst) begin
      im  <= '0;
      ie  <= 1'b0;
      exl <= 1'b0;
    end else begin
      if (wr_sr) begin
        im <= DIn[15:10];
        ie <= DIn[0];
      end
      if (EXLSet)
        exl <= 1'b1;
      else if (EXLClr)
        exl <= 1'b0;
      else if (wr_sr)
        exl <= DIn[1];
    end
  end

  // Cause.IP: plain one-stage sample, never blocked
  always_ff @(posedge clk) begin
    if (rst)
      ip <= '0;
    else
      ip <= HWInt;
  end

  // EPC: hardware capture wins over MTC0
  always_ff @(posedge clk) begin
    if (rst)
      epc_q <= '0;
    else if (EPCWr)
      epc_q <= PC;
    else if (wr_epc)
      epc_q <= DIn[31:2];
  end

  // Registered sources only, so HWInt has no direct path here.
  assign IntReq = ie & ~exl & (|(ip & im));
  assign EPC    = epc_q;

  always_comb begin
    DOut = '0;
    unique case (A1)
      R_SR:    DOut = {16'b0, im, 8'b0, exl, ie};
      R_CAUSE: DOut = {16'b0, ip, 3'b0, 5'b0, 2'b0};
      R_EPC:   DOut = {epc_q, 2'b00};
      R_PRID:  DOut = PRID_VAL;
      default: DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: vector table + scoreboard bench for cp0.
// Drives on negedge, compares 1ns after posedge.
module tb_cp0;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  A1, A2;
  logic [31:0] DIn;
  logic [29:0] PC;
  logic [5:0]  HWInt;
  logic        We, EXLSet, EXLClr, EPCWr;
  logic        IntReq;
  logic [29:0] EPC;
  logic [31:0] DOut;

  int checks = 0;
  int errors = 0;

  cp0 dut (
    .clk(clk), .rst(rst), .A1(A1), .A2(A2), .DIn(DIn), .PC(PC),
    .HWInt(HWInt), .We(We), .EXLSet(EXLSet), .EXLClr(EXLClr),
    .EPCWr(EPCWr), .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ctl;
    logic [4:0]  a2;
    logic [31:0] din;
    logic [29:0] pc;
    logic [5:0]  hw;
    logic [4:0]  a1;
    logic [31:0] xdout;
    logic        xirq;
    logic [29:0] xepc;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] xdout;
    logic        xirq;
    logic [29:0] xepc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  // ctl = {rst, We, EXLSet, EXLClr, EPCWr}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_RST  = 5'b10000;
  localparam logic [4:0] C_WE   = 5'b01000;
  localparam logic [4:0] C_ENT  = 5'b01101;
  localparam logic [4:0] C_RET  = 5'b01010;
  localparam logic [4:0] C_BOTH = 5'b01110;
  localparam logic [4:0] C_EPCW = 5'b01001;
  localparam logic [4:0] C_RSTE = 5'b11101;

  function automatic vec_t mk(
    logic [4:0] ctl, logic [4:0] a2, logic [31:0] din,
    logic [29:0] pc, logic [5:0] hw, logic [4:0] a1,
    logic [31:0] xdout, logic xirq, logic [29:0] xepc);
    vec_t v;
    v.ctl = ctl; v.a2 = a2; v.din = din; v.pc = pc;
    v.hw = hw; v.a1 = a1; v.xdout = xdout;
    v.xirq = xirq; v.xepc = xepc;
    return v;
  endfunction

  task automatic chk(string nm, int idx,
                     logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%h required=%h",
               nm, idx, act, exp);
    end
  endtask

  // Scoreboard consumer: one expected record per clock edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("dout", e.idx, DOut, e.xdout);
      chk("intreq", e.idx, {31'b0, IntReq}, {31'b0, e.xirq});
      chk("epc", e.idx, {2'b0, EPC}, {2'b0, e.xepc});
    end
  end

  task automatic drive(vec_t v);
    {rst, We, EXLSet, EXLClr, EPCWr} = v.ctl;
    A2 = v.a2; DIn = v.din; PC = v.pc;
    HWInt = v.hw; A1 = v.a1;
  endtask

  initial begin
    exp_t e;
    vec_t v;
    int   wait_cnt;

    rst = 1'b1; We = 0; EXLSet = 0; EXLClr = 0; EPCWr = 0;
    A1 = 0; A2 = 0; DIn = 0; PC = 0; HWInt = 0;

    // ctl, a2, din, pc, hw, a1, xdout, xirq, xepc
    tbl.push_back(mk(C_RST, 0, 0, 0, 0, 12, 0, 0, 0));
    tbl.push_back(mk(C_RST, 0, 0, 0, 0, 13, 0, 0, 0));
    tbl.push_back(mk(C_WE, 12, 32'h401, 0, 0, 12, 32'h401, 0, 0));
    tbl.push_back(mk(C_NONE, 0, 0, 0, 6'h01, 12, 32'h401, 1, 0));
    tbl.push_back(mk(C_NONE, 0, 0, 0, 6'h01, 13, 32'h400, 1, 0));
    tbl.push_back(mk(C_ENT, 0, 0, 30'hC05, 6'h01, 14,
                     32'h3014, 0, 30'hC05));
    tbl.push_back(mk(C_NONE, 0, 0, 0, 6'h01, 12, 32'h403, 0, 30'hC05));
    tbl.push_back(mk(C_RET, 0, 0, 0, 6'h01, 12, 32'h401, 1, 30'hC05));
    tbl.push_back(mk(C_NONE, 0, 0, 0, 6'h00, 12, 32'h401, 0, 30'hC05));
    tbl.push_back(mk(C_NONE, 0, 0, 0, 6'h20, 13, 32'h8000, 0, 30'hC05));
    tbl.push_back(mk(C_WE, 12, 32'hFC00, 0, 6'h20, 12,
                     32'hFC00, 0, 30'hC05));
    tbl.push_back(mk(C_WE, 13, 32'hFFFF_FFFF, 0, 6'h20, 13,
                     32'h8000, 0, 30'hC05));
    tbl.push_back(mk(C_NONE, 0, 0, 0, 6'h20, 15,
                     32'h0000_4D50, 0, 30'hC05));
    tbl.push_back(mk(C_NONE, 0, 0, 0, 6'h20, 3, 0, 0, 30'hC05));
    tbl.push_back(mk(C_WE, 12, 32'hFC01, 0, 6'h20, 12,
                     32'hFC01, 1, 30'hC05));
    tbl.push_back(mk(C_ENT, 14, 32'h1234_5678, 30'h10, 6'h20, 14,
                     32'h40, 0, 30'h10));
    tbl.push_back(mk(C_NONE, 0, 0, 0, 6'h20, 12, 32'hFC03, 0, 30'h10));
    tbl.push_back(mk(C_BOTH, 12, 0, 0, 6'h20, 12, 32'hFC03, 0, 30'h10));
    tbl.push_back(mk(C_WE, 14, 32'hABCD_0007, 0, 6'h20, 14,
                     32'hABCD_0004, 0, 30'h2AF3_4001));
    tbl.push_back(mk(C_EPCW, 14, 32'hFFFF_FFFC, 30'h123, 6'h20, 14,
                     32'h48C, 0, 30'h123));
    tbl.push_back(mk(C_RET, 0, 0, 0, 6'h20, 12, 32'hFC01, 1, 30'h123));
    tbl.push_back(mk(C_RSTE, 14, 32'hFFFF_FFFF, 30'h55, 6'h20, 12,
                     0, 0, 0));
    tbl.push_back(mk(C_NONE, 0, 0, 0, 6'h20, 13, 32'h8000, 0, 0));
    tbl.push_back(mk(C_NONE, 0, 0, 0, 6'h20, 14, 0, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      v = tbl[i];
      drive(v);
      e.idx = i; e.xdout = v.xdout;
      e.xirq = v.xirq; e.xepc = v.xepc;
      sb.push_back(e);
    end

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
      sb.delete();
    end

    // IntReq latency: no combinational path from HWInt.
    @(negedge clk);
    drive(mk(C_WE, 12, 32'h401, 0, 0, 12, 0, 0, 0));
    @(negedge clk);
    drive(mk(C_NONE, 0, 0, 0, 6'h01, 12, 0, 0, 0));
    #1;
    chk("lat_pre", 0, {31'b0, IntReq}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_post", 0, {31'b0, IntReq}, 32'd1);
    @(negedge clk);
    drive(mk(C_NONE, 0, 0, 0, 6'h00, 12, 0, 0, 0));
    #1;
    chk("drop_pre", 0, {31'b0, IntReq}, 32'd1);
    @(posedge clk);
    #1;
    chk("drop_post", 0, {31'b0, IntReq}, 32'd0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
